alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
- Multi-cycle issue/write-back controller sitting directly upstream and downstream of the registered 8-bit ALU.
- Accepts one instruction per handshake and reads two operands from an internal 4-entry register file.
- Drives the ALU operand and opcode inputs, waits for the ALU's output flop, then writes the result back to the destination register.
- Also provides a direct load port for seeding registers and a combinational debug read port.

Parameters:
WIDTH, 8, data width; must match the ALU WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
instr_valid  input  1  instruction offered.
instr_ready  output  1  controller can accept an instruction.
instr_op  input  3  ALU opcode: 000 AND, 001 OR, 010 XOR, 011 NOT(a), 100 ADD, 101 SUB, 110 DEC, 111 INC.
instr_rd  input  2  destination register index.
instr_rs1  input  2  source register for operand a.
instr_rs2  input  2  source register for operand b.
ld_valid  input  1  direct register-file write request.
ld_addr  input  2  load destination index.
ld_data  input  WIDTH  load data.
dbg_addr  input  2  debug read index.
dbg_data  output  WIDTH  RF[dbg_addr], combinational.
alu_a  output  WIDTH  to ALU a.
alu_b  output  WIDTH  to ALU b.
alu_op  output  3  to ALU alucontrol.
alu_result  input  WIDTH  from ALU registered result.
alu_cout  input  1  from ALU adder carry (combinational in the ALU).
done  output  1  one-cycle pulse during the write-back cycle.
busy  output  1  high whenever state != IDLE.
carry_flag  output  1  see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; RF[0..3]=0; latched instruction fields=0.
  - done=0, busy=0, carry_flag=0, alu_a/alu_b/alu_op=0.
- States: IDLE -> EXEC -> WB -> IDLE. Fixed 3-cycle occupancy, so throughput is one instruction per 3 cycles.
- IDLE:
  - instr_ready = ~ld_valid.
  - If ld_valid=1: RF[ld_addr]<=ld_data at the edge. Load has priority, so no instruction is accepted that cycle.
  - Else if instr_valid=1: latch op/rd/rs1/rs2 and go to EXEC.
  - alu_* outputs are 0.
- EXEC:
  - alu_a=RF[rs1], alu_b=RF[rs2], alu_op=op (combinational from the latched fields).
  - The ALU flop captures its result at the end of this cycle; alu_cout is sampled at the same edge.
  - instr_ready=0. Go to WB.
- WB:
  - done=1. RF[rd]<=alu_result at the edge. Go to IDLE.
  - alu_* outputs are 0. instr_ready=0.
- ld_valid outside IDLE is ignored; no write occurs and no queueing is performed.
- rs1==rs2 is legal; both operands read the same entry.
- rd equal to a source is legal, because operands are read in EXEC before the write in WB.
- Arithmetic: wrap-around modulo 2^WIDTH is performed by the ALU. The controller never alters result width.
- An instruction issued in the cycle after done sees the written-back value; no hazard exists.
- Reset mid-EXEC or mid-WB aborts the instruction: no RF write, no done pulse after reset.
- dbg_data reflects RF contents at all times, including during WB before the edge (old value).

Optional Feature:
Macro ALU_CTRL_CARRY_EN.
- Defined:
  - carry_flag register is loaded with alu_cout at the end of EXEC when op=100 (ADD).
  - For every other op, carry_flag holds its value.
  - Reset clears it to 0.
- Undefined: carry_flag tied to 0 and alu_cout is unused.

Test Plan:
- Reset then dbg_addr sweep 0..3 -> dbg_data=0 for all; busy=0, instr_ready=1.
- Load RF0=8'h3C, RF1=8'h0F; issue op=100 rd=2 rs1=0 rs2=1 -> alu_a=3C, alu_b=0F in EXEC; done pulses 2 cycles after accept; RF2=8'h4B.
- Load RF0=8'hF0, RF1=8'h20; ADD rd=3 -> RF3=8'h10. With ALU_CTRL_CARRY_EN, carry_flag=1 and stays 1 across a following XOR; without it, carry_flag=0.
- ld_valid=1 and instr_valid=1 in the same IDLE cycle -> load written, instr_ready=0, instruction accepted the next cycle. ld_valid during EXEC -> RF unchanged.
- INC rd=0 rs1=0 with RF0=8'hFF -> RF0=8'h00. SUB rd=1 rs1=1 rs2=1 -> RF1=0.
- Assert reset during EXEC of ADD rd=2 -> busy=0 immediately, no done pulse, RF2=0.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: instruction, load, debug and ALU-side signals of the
// alu_ctrl issue/write-back controller.
//   slave  : seen from the controller
//   master : seen from whatever drives the controller (and models the ALU)
interface alu_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             instr_valid;
   logic             instr_ready;
   logic [2:0]       instr_op;
   logic [1:0]       instr_rd;
   logic [1:0]       instr_rs1;
   logic [1:0]       instr_rs2;
   logic             ld_valid;
   logic [1:0]       ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic [1:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             done;
   logic             busy;
   logic             carry_flag;

   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
      input  ld_valid, ld_addr, ld_data, dbg_addr,
      input  alu_result, alu_cout,
      output instr_ready, dbg_data, alu_a, alu_b, alu_op,
      output done, busy, carry_flag
   );

   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
      output ld_valid, ld_addr, ld_data, dbg_addr,
      output alu_result, alu_cout,
      input  instr_ready, dbg_data, alu_a, alu_b, alu_op,
      input  done, busy, carry_flag
   );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: issue/write-back controller around a registered 8-bit ALU.
// Owns a 4-entry register file, issues one instruction every 3 cycles
// (IDLE -> EXEC -> WB) and writes the ALU result back in WB.
// Optional feature macro: ALU_CTRL_CARRY_EN (ADD carry-out flag).
//
// The ALU operand/opcode outputs are registered: they are captured from the
// register file at the accept edge. This equals reading RF[rs1]/RF[rs2]
// during EXEC because the register file cannot change while in EXEC
// (loads are only honoured in IDLE, and a load blocks acceptance).
module alu_ctrl #(
   parameter int WIDTH = 8
) (
   input logic        clk,
   input logic        reset,
   alu_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      WB   = 2'b10
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b100;

   state_t           state_r;
   state_t           state_s;
   logic             accept_s;
   logic             load_s;

   logic [WIDTH-1:0] rf_r [4];
   logic [2:0]       op_r;
   logic [1:0]       rd_r;

   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [2:0]       alu_op_r;
   logic             done_r;
   logic             busy_r;

   // Next-state decode and the load/accept strobes for the IDLE state.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      load_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.ld_valid) begin
               load_s  = 1'b1;
               state_s = IDLE;
            end else if (bus.instr_valid) begin
               accept_s = 1'b1;
               state_s  = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC:    state_s = WB;
         WB:      state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Latched instruction fields and registered ALU-side / status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r     <= 3'b000;
         rd_r     <= 2'b00;
         alu_a_r  <= {WIDTH{1'b0}};
         alu_b_r  <= {WIDTH{1'b0}};
         alu_op_r <= 3'b000;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else if (accept_s) begin
         op_r     <= bus.instr_op;
         rd_r     <= bus.instr_rd;
         alu_a_r  <= rf_r[bus.instr_rs1];
         alu_b_r  <= rf_r[bus.instr_rs2];
         alu_op_r <= bus.instr_op;
         done_r   <= 1'b0;
         busy_r   <= 1'b1;
      end else if (state_r == EXEC) begin
         alu_a_r  <= {WIDTH{1'b0}};
         alu_b_r  <= {WIDTH{1'b0}};
         alu_op_r <= 3'b000;
         done_r   <= 1'b1;
         busy_r   <= 1'b1;
      end else if (state_r == WB) begin
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         done_r   <= 1'b0;
         busy_r   <= busy_r;
      end
   end

   // Register file: direct load in IDLE wins, otherwise write-back in WB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            rf_r[i] <= {WIDTH{1'b0}};
         end
      end else if (load_s) begin
         rf_r[bus.ld_addr] <= bus.ld_data;
      end else if (state_r == WB) begin
         rf_r[rd_r] <= bus.alu_result;
      end else begin
         rf_r[rd_r] <= rf_r[rd_r];
      end
   end

`ifdef ALU_CTRL_CARRY_EN
   logic carry_r;

   // Carry flag follows the adder carry only for ADD, sampled at the end of EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_r <= 1'b0;
      end else if ((state_r == EXEC) && (op_r == OP_ADD)) begin
         carry_r <= bus.alu_cout;
      end else begin
         carry_r <= carry_r;
      end
   end

   assign bus.carry_flag = carry_r;
`else
   logic unused_cout;
   logic [2:0] unused_op;

   assign unused_cout    = bus.alu_cout;
   assign unused_op      = op_r ^ OP_ADD;
   assign bus.carry_flag = 1'b0;
`endif

   assign bus.instr_ready = (state_r == IDLE) && !bus.ld_valid;
   assign bus.dbg_data    = rf_r[bus.dbg_addr];
   assign bus.alu_a       = alu_a_r;
   assign bus.alu_b       = alu_b_r;
   assign bus.alu_op      = alu_op_r;
   assign bus.done        = done_r;
   assign bus.busy        = busy_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed + randomized bench for alu_ctrl. A registered ALU
// is modelled next to the DUT; expected register-file contents come from an
// integer-arithmetic reference model of the instruction set.
module tb_alu_ctrl;

   logic clk = 1'b0;
   logic reset;

   always #10 clk = ~clk;

   alu_ctrl_if #(.WIDTH(8)) bus();

   alu_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int rf_m [4];
   int carry_m;

   // Registered ALU with a combinational adder carry.
   logic [8:0] sum9;
   assign sum9         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
   assign bus.alu_cout = sum9[8];

   always @(posedge clk) begin
      case (bus.alu_op)
         3'd0:    bus.alu_result <= bus.alu_a & bus.alu_b;
         3'd1:    bus.alu_result <= bus.alu_a | bus.alu_b;
         3'd2:    bus.alu_result <= bus.alu_a ^ bus.alu_b;
         3'd3:    bus.alu_result <= ~bus.alu_a;
         3'd4:    bus.alu_result <= bus.alu_a + bus.alu_b;
         3'd5:    bus.alu_result <= bus.alu_a - bus.alu_b;
         3'd6:    bus.alu_result <= bus.alu_a - 8'd1;
         default: bus.alu_result <= bus.alu_a + 8'd1;
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Reference instruction semantics in plain integer arithmetic.
   function automatic int ref_alu(input int op, input int a, input int b);
      case (op)
         0:       return a & b;
         1:       return a | b;
         2:       return a ^ b;
         3:       return 255 - a;
         4:       return (a + b) % 256;
         5:       return (a - b + 256) % 256;
         6:       return (a + 255) % 256;
         default: return (a + 1) % 256;
      endcase
   endfunction

   function automatic int exp_carry();
`ifdef ALU_CTRL_CARRY_EN
      return carry_m;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 4; i++) begin
         bus.dbg_addr = 2'(i);
         #1;
         check($sformatf("%s_rf%0d", tag, i), 32'(bus.dbg_data), rf_m[i]);
      end
   endtask

   task automatic do_load(input int a, input int d);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 2'(a);
      bus.ld_data  = 8'(d);
      #1;
      check("ld_ready_low", 32'(bus.instr_ready), 0);
      tick();
      bus.ld_valid = 1'b0;
      rf_m[a] = d;
   endtask

   task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                        input bit ld_exec, input bit abort);
      int expv;
      bus.instr_valid = 1'b1;
      bus.instr_op    = 3'(op);
      bus.instr_rd    = 2'(rd);
      bus.instr_rs1   = 2'(rs1);
      bus.instr_rs2   = 2'(rs2);
      #1;
      check("idle_ready", 32'(bus.instr_ready), 1);
      check("idle_busy", 32'(bus.busy), 0);
      tick();
      // EXEC
      bus.instr_valid = 1'b0;
      bus.instr_op    = 3'd0;
      if (ld_exec) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = 2'((rd + 1) % 4);
         bus.ld_data  = 8'h5A;
      end
      #1;
      check("exec_busy", 32'(bus.busy), 1);
      check("exec_ready", 32'(bus.instr_ready), 0);
      check("exec_done", 32'(bus.done), 0);
      check("exec_alu_a", 32'(bus.alu_a), rf_m[rs1]);
      check("exec_alu_b", 32'(bus.alu_b), rf_m[rs2]);
      check("exec_alu_op", 32'(bus.alu_op), op);
      expv = ref_alu(op, rf_m[rs1], rf_m[rs2]);
      if (abort) begin
         reset = 1'b1;
         #1;
         check("abort_busy", 32'(bus.busy), 0);
         check("abort_done", 32'(bus.done), 0);
         check("abort_alu_a", 32'(bus.alu_a), 0);
         bus.ld_valid = 1'b0;
         tick();
         tick();
         reset = 1'b0;
         for (int i = 0; i < 4; i++) rf_m[i] = 0;
         carry_m = 0;
         for (int c = 0; c < 3; c++) begin
            #1;
            check("abort_no_done", 32'(bus.done), 0);
            tick();
         end
         sweep("abort");
         check("abort_carry", 32'(bus.carry_flag), exp_carry());
      end else begin
         if (op == 4) carry_m = ((rf_m[rs1] + rf_m[rs2]) > 255) ? 1 : 0;
         tick();
         // WB
         bus.ld_valid = 1'b0;
         bus.dbg_addr = 2'(rd);
         #1;
         check("wb_done", 32'(bus.done), 1);
         check("wb_busy", 32'(bus.busy), 1);
         check("wb_ready", 32'(bus.instr_ready), 0);
         check("wb_alu_a", 32'(bus.alu_a), 0);
         check("wb_alu_op", 32'(bus.alu_op), 0);
         check("wb_dbg_old", 32'(bus.dbg_data), rf_m[rd]);
         tick();
         // back in IDLE
         rf_m[rd] = expv;
         #1;
         check("post_done", 32'(bus.done), 0);
         check("post_busy", 32'(bus.busy), 0);
         check("post_carry", 32'(bus.carry_flag), exp_carry());
         sweep("post");
      end
   endtask

   initial begin
      int op, rd, rs1, rs2;
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr_op    = 3'd0;
      bus.instr_rd    = 2'd0;
      bus.instr_rs1   = 2'd0;
      bus.instr_rs2   = 2'd0;
      bus.ld_valid    = 1'b0;
      bus.ld_addr     = 2'd0;
      bus.ld_data     = 8'd0;
      bus.dbg_addr    = 2'd0;
      for (int i = 0; i < 4; i++) rf_m[i] = 0;
      carry_m = 0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_ready", 32'(bus.instr_ready), 1);
      check("rst_done", 32'(bus.done), 0);
      check("rst_carry", 32'(bus.carry_flag), 0);
      check("rst_alu_a", 32'(bus.alu_a), 0);
      check("rst_alu_b", 32'(bus.alu_b), 0);
      check("rst_alu_op", 32'(bus.alu_op), 0);
      sweep("rst");
      tick();

      // Basic ADD
      do_load(0, 8'h3C);
      do_load(1, 8'h0F);
      issue(4, 2, 0, 1, 1'b0, 1'b0);
      check("add_rf2", rf_m[2], 8'h4B);

      // ADD with carry, then XOR that must leave the carry flag alone
      do_load(0, 8'hF0);
      do_load(1, 8'h20);
      issue(4, 3, 0, 1, 1'b0, 1'b0);
      issue(2, 2, 1, 1, 1'b0, 1'b0);

      // Load and instruction offered together: load wins, instr next cycle
      bus.instr_valid = 1'b1;
      bus.instr_op    = 3'd1;
      bus.instr_rd    = 2'd1;
      bus.instr_rs1   = 2'd0;
      bus.instr_rs2   = 2'd3;
      bus.ld_valid    = 1'b1;
      bus.ld_addr     = 2'd3;
      bus.ld_data     = 8'h0C;
      #1;
      check("prio_ready", 32'(bus.instr_ready), 0);
      tick();
      bus.ld_valid = 1'b0;
      rf_m[3] = 8'h0C;
      #1;
      check("prio_not_accepted", 32'(bus.busy), 0);
      issue(1, 1, 0, 3, 1'b1, 1'b0);

      // Wrap-around cases
      do_load(0, 8'hFF);
      issue(7, 0, 0, 0, 1'b0, 1'b0);
      issue(5, 1, 1, 1, 1'b1, 1'b0);

      // Randomized instruction stream
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, 3), $urandom_range(0, 255));
         op  = $urandom_range(0, 7);
         rd  = $urandom_range(0, 3);
         rs1 = $urandom_range(0, 3);
         rs2 = $urandom_range(0, 3);
         issue(op, rd, rs1, rs2, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset during EXEC aborts the write-back
      do_load(0, 8'h81);
      do_load(1, 8'h92);
      issue(4, 2, 0, 1, 1'b0, 1'b1);
      do_load(3, 8'h11);
      issue(7, 2, 3, 3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
